thread_sched: RTL and testbench
===============================

# thread_sched

Per-core thread scheduler and pipeline-stage controller for the md5crypt CPU. It initialises all threads and scans thread states in the background to pre-select the next thread in WR_RDY state. On NEXT_THREAD it switches to that thread and asserts RELOAD so the instruction unit can load that thread's instruction pointer. It also drives the `stage_allow` fill/stall/flush mask for the fetch/decode pipeline.

## Interface
- N_THREADS, 16: threads per core; power of 2, ≥2. TN = clog2(N_THREADS) bits.
- N_STAGES, 4: pipeline stages controlled by `stage_allow`; ≥2.
- CLK in 1: clock, all logic on the rising edge.
- RST in 1: reset, asynchronous and active-high.
- entry_pt_switch in 1: program entry point changed; restarts initialisation.
- ts_rd_num out TN: thread-state read address.
- ts_rd in 2: state of thread `ts_rd_num`; combinational (async) read, valid in the same cycle.
- NEXT_THREAD in 1: current thread yields (may coincide with JUMP/EXECUTED elsewhere).
- INVALIDATE in 1: flush the pipeline; arrives 1 cycle before NEXT_THREAD when a thread switches.
- INSTR_WAIT in 1: stall the pipeline.
- RELOAD out 1: combinational; load the IP of `thread_num_ahead` this cycle.
- thread_num out TN: currently executing thread (registered).
- thread_num_ahead out TN: pre-selected next thread (registered).
- thread_init out 1: initialisation phase; `thread_num` sweeps all threads.
- thread_almost_switched out 1: registered; high for 1 cycle, one cycle before the new thread's first instruction is output.
- stage_allow out N_STAGES: per-stage enable mask (registered).
- err out 1: sticky protocol error flag.

## Operation
- **Thread states** (2-bit): 0 NONE, 1 WR_RDY, 2 RUNNING, 3 WAIT. Only WR_RDY is eligible for selection.
- **Init**
  - Entered on RST release or on `entry_pt_switch` (synchronous, any time; aborts any pending switch and clears `ahead_valid`).
  - `thread_init`=1 for exactly N_THREADS cycles while `thread_num` counts 0..N_THREADS-1 (downstream writes entry points).
  - After init, `switch_pending` is set so the first ready thread gets loaded.
  - No RELOAD is issued during init.
- **Scan** (when not init and `ahead_valid`=0)
  - `ts_rd_num` increments by 1 each cycle, wrapping at N_THREADS.
  - When `ts_rd`==WR_RDY and `ts_rd_num`≠`thread_num`: `thread_num_ahead`<=`ts_rd_num`, `ahead_valid`<=1.
- **Hold** (`ahead_valid`=1)
  - `ts_rd_num` is held at `thread_num_ahead`.
  - If `ts_rd`≠WR_RDY, `ahead_valid`<=0 and scanning resumes from `thread_num_ahead`+1.
- **Switch**
  - NEXT_THREAD sets `switch_pending`.
  - RELOAD = (NEXT_THREAD | `switch_pending`) & `ahead_valid` & ~`thread_init`. RELOAD may therefore come in the same cycle as NEXT_THREAD or later.
  - On RELOAD:
    - `thread_num`<=`thread_num_ahead`;
    - `switch_pending`<=0;
    - `ahead_valid`<=0;
    - scanning resumes at `thread_num_ahead`+1.
  - A NEXT_THREAD arriving while `switch_pending`=1 is absorbed (no double switch).
- **Stage mask.** Priority, first match wins:
  1. RELOAD → next `stage_allow` = 0…01.
  2. INVALIDATE → 0.
  3. INSTR_WAIT → hold.
  4. Otherwise → {`stage_allow`[N_STAGES-2:0], `stage_allow`[0]}. The mask fills 0001→0011→0111→1111, and an all-zero mask stays zero.
- **thread_almost_switched** <= RELOAD, i.e. high in the cycle where `stage_allow` first reads 0…01.
- **err** <= err | (INVALIDATE & RELOAD); cleared only by RST.

## Timing
- Reset values:
  - `thread_num`=0, `thread_num_ahead`=0, `ts_rd_num`=0;
  - `stage_allow`=0, `thread_almost_switched`=0, `err`=0;
  - `ahead_valid`=0, `switch_pending`=0;
  - `thread_init`=1 (init starts on the first edge after release).
- Selection latency: a WR_RDY thread k positions ahead of the scan pointer is captured after k+1 edges.
- Switch latency: 0 cycles from NEXT_THREAD to RELOAD when `ahead_valid`=1. Otherwise RELOAD comes in the first cycle where `ahead_valid`=1.
- The new thread's first instruction is available 2 cycles after RELOAD.
- Only thread (`thread_num`) is WR_RDY: it is never selected and the switch waits. `thread_num` itself keeps its old value until RELOAD.

## Structure
- Shared package `md5_cpu_pkg`:
  - thread-state encodings (THREAD_STATE_WR_RDY etc.);
  - THREAD_STATE width;
  - default N_THREADS and N_STAGES.
- One sub-module `stage_ctrl`: the `stage_allow`, `thread_almost_switched` and `err` logic, with inputs INVALIDATE, INSTR_WAIT and RELOAD.
- Scanner, init counter and switch logic live in the top level.

## Test plan
- Reset, then hold `ts_rd`=NONE for all threads → `thread_init`=1 for 16 cycles with `thread_num` 0..15, then 0; no RELOAD; `stage_allow`=0.
- After init, only thread 5 is WR_RDY → `thread_num_ahead`=5, `ahead_valid` set, RELOAD fires (pending from init) → `thread_num`=5; `stage_allow` goes 0001, 0011, 0111, 1111 on consecutive cycles; `thread_almost_switched`=1 only in the 0001 cycle.
- Thread 5 running and thread 9 pre-selected; pulse INVALIDATE then NEXT_THREAD → `stage_allow`=0, RELOAD in the NEXT_THREAD cycle, then `thread_num`=9 and mask 0001; `err` stays 0.
- INSTR_WAIT held 3 cycles at mask 0011 → mask stays 0011, then resumes to 0111.
- Pre-selected thread 3 drops out of WR_RDY before NEXT_THREAD → `ahead_valid` clears, scan resumes at 4; RELOAD is delayed until thread 7 (WR_RDY) is captured.
- INVALIDATE and RELOAD in the same cycle → `err`=1 and stays set; `entry_pt_switch` mid-run → `thread_init` sweep restarts and any pending switch is cancelled.

Source files
------------

// File: rtl/md5_cpu_pkg.sv
// Shared definitions for the md5crypt CPU: thread-state encodings and
// default core geometry.
package md5_cpu_pkg;

  localparam int THREAD_STATE_W = 2;

  typedef enum logic [THREAD_STATE_W-1:0] {
    THREAD_STATE_NONE    = 2'd0,
    THREAD_STATE_WR_RDY  = 2'd1,
    THREAD_STATE_RUNNING = 2'd2,
    THREAD_STATE_WAIT    = 2'd3
  } thread_state_e;

  localparam int DEF_N_THREADS = 16;
  localparam int DEF_N_STAGES  = 4;

endpackage

// File: rtl/thread_sched_stage_ctrl.sv
// Fetch/decode pipeline enable mask: fills one stage per cycle after a
// reload, flushes on invalidate, freezes on instruction wait.
module stage_ctrl
  import md5_cpu_pkg::*;
#(
  parameter int N_STAGES = DEF_N_STAGES
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                INVALIDATE,
  input  logic                INSTR_WAIT,
  input  logic                RELOAD,
  output logic [N_STAGES-1:0] stage_allow,
  output logic                thread_almost_switched,
  output logic                err
);

  localparam logic [N_STAGES-1:0] FIRST_ONLY = {{(N_STAGES-1){1'b0}}, 1'b1};

  logic [N_STAGES-1:0] r_stage_allow;
  logic [N_STAGES-1:0] w_stage_allow_nxt;
  logic                r_almost;
  logic                r_err;

  // Reload wins over invalidate so a new thread always starts filling.
  always_comb begin
    w_stage_allow_nxt = {r_stage_allow[N_STAGES-2:0], r_stage_allow[0]};
    if (RELOAD)
      w_stage_allow_nxt = FIRST_ONLY;
    else if (INVALIDATE)
      w_stage_allow_nxt = '0;
    else if (INSTR_WAIT)
      w_stage_allow_nxt = r_stage_allow;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_stage_allow <= '0;
      r_almost      <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_stage_allow <= w_stage_allow_nxt;
      r_almost      <= RELOAD;
      r_err         <= r_err | (INVALIDATE & RELOAD);
    end
  end

  assign stage_allow            = r_stage_allow;
  assign thread_almost_switched = r_almost;
  assign err                    = r_err;

endmodule

// File: rtl/thread_sched.sv
// Per-core thread scheduler: initial thread sweep, background scan for the
// next WR_RDY thread, and switch/reload control.
module thread_sched
  import md5_cpu_pkg::*;
#(
  parameter  int N_THREADS = DEF_N_THREADS,
  parameter  int N_STAGES  = DEF_N_STAGES,
  localparam int TN        = $clog2(N_THREADS)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      entry_pt_switch,
  output logic [TN-1:0]             ts_rd_num,
  input  logic [THREAD_STATE_W-1:0] ts_rd,
  input  logic                      NEXT_THREAD,
  input  logic                      INVALIDATE,
  input  logic                      INSTR_WAIT,
  output logic                      RELOAD,
  output logic [TN-1:0]             thread_num,
  output logic [TN-1:0]             thread_num_ahead,
  output logic                      thread_init,
  output logic                      thread_almost_switched,
  output logic [N_STAGES-1:0]       stage_allow,
  output logic                      err
);

  localparam logic [TN-1:0] LAST_THREAD = TN'(N_THREADS - 1);

  // HOLD means a WR_RDY thread is pre-selected (ahead_valid).
  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOLD = 2'd2
  } sched_state_e;

  sched_state_e  r_state, w_state_nxt;
  logic [TN-1:0] r_thread_num, w_thread_num_nxt;
  logic [TN-1:0] r_ahead, w_ahead_nxt;
  logic [TN-1:0] r_ptr, w_ptr_nxt;
  logic          r_pending, w_pending_nxt;

  logic          w_rdy;
  logic          w_reload;
  logic [TN-1:0] w_ahead_inc;

  assign w_rdy       = (ts_rd == THREAD_STATE_WR_RDY);
  assign w_ahead_inc = r_ahead + TN'(1);
  assign w_reload    = (NEXT_THREAD | r_pending) & (r_state == ST_HOLD);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= ST_INIT;
      r_thread_num <= '0;
      r_ahead      <= '0;
      r_ptr        <= '0;
      r_pending    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_thread_num <= w_thread_num_nxt;
      r_ahead      <= w_ahead_nxt;
      r_ptr        <= w_ptr_nxt;
      r_pending    <= w_pending_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_thread_num_nxt = r_thread_num;
    w_ahead_nxt      = r_ahead;
    w_ptr_nxt        = r_ptr;
    w_pending_nxt    = r_pending;
    if (entry_pt_switch) begin
      w_state_nxt      = ST_INIT;
      w_thread_num_nxt = '0;
      w_ptr_nxt        = '0;
      w_pending_nxt    = 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          w_thread_num_nxt = r_thread_num + TN'(1);
          // First ready thread after the sweep must be loaded unprompted.
          if (r_thread_num == LAST_THREAD) begin
            w_state_nxt   = ST_SCAN;
            w_pending_nxt = 1'b1;
          end
        end
        ST_SCAN: begin
          if (NEXT_THREAD)
            w_pending_nxt = 1'b1;
          if (w_rdy && (r_ptr != r_thread_num)) begin
            w_ahead_nxt = r_ptr;
            w_state_nxt = ST_HOLD;
          end else begin
            w_ptr_nxt = r_ptr + TN'(1);
          end
        end
        ST_HOLD: begin
          if (w_reload) begin
            w_thread_num_nxt = r_ahead;
            w_pending_nxt    = 1'b0;
            w_state_nxt      = ST_SCAN;
            w_ptr_nxt        = w_ahead_inc;
          end else begin
            if (NEXT_THREAD)
              w_pending_nxt = 1'b1;
            if (!w_rdy) begin
              w_state_nxt = ST_SCAN;
              w_ptr_nxt   = w_ahead_inc;
            end
          end
        end
        default: w_state_nxt = ST_INIT;
      endcase
    end
  end

  stage_ctrl #(.N_STAGES(N_STAGES)) u_stage_ctrl (
    .CLK                    (CLK),
    .RST                    (RST),
    .INVALIDATE             (INVALIDATE),
    .INSTR_WAIT             (INSTR_WAIT),
    .RELOAD                 (w_reload),
    .stage_allow            (stage_allow),
    .thread_almost_switched (thread_almost_switched),
    .err                    (err)
  );

  assign RELOAD           = w_reload;
  assign ts_rd_num        = r_ptr;
  assign thread_num       = r_thread_num;
  assign thread_num_ahead = r_ahead;
  assign thread_init      = (r_state == ST_INIT);

endmodule

// File: tb/tb_thread_sched.sv
// Self-checking bench for thread_sched: vector table for the stage mask,
// scripted scan/switch corner cases, and a reload scoreboard.
module tb_thread_sched;
  import md5_cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       entry_pt_switch = 1'b0;
  logic [3:0] ts_rd_num;
  logic [1:0] ts_rd;
  logic       next_thread = 1'b0;
  logic       invalidate = 1'b0;
  logic       instr_wait = 1'b0;
  logic       reload;
  logic [3:0] thread_num;
  logic [3:0] thread_num_ahead;
  logic       thread_init;
  logic       almost;
  logic [3:0] stage_allow;
  logic       err;

  logic [1:0] tstate [16];
  assign ts_rd = tstate[ts_rd_num];

  int n_chk = 0;
  int n_fail = 0;
  int exp_q[$];
  logic prev_rel = 1'b0;

  always #5 clk = ~clk;

  thread_sched #(.N_THREADS(16), .N_STAGES(4)) dut (
    .CLK(clk), .RST(rst), .entry_pt_switch(entry_pt_switch),
    .ts_rd_num(ts_rd_num), .ts_rd(ts_rd), .NEXT_THREAD(next_thread),
    .INVALIDATE(invalidate), .INSTR_WAIT(instr_wait), .RELOAD(reload),
    .thread_num(thread_num), .thread_num_ahead(thread_num_ahead),
    .thread_init(thread_init), .thread_almost_switched(almost),
    .stage_allow(stage_allow), .err(err)
  );

  typedef struct {
    logic       inv;
    logic       iw;
    logic       nt;
    logic       rel;
    logic [3:0] sa;
    logic       alm;
  } vec_t;
  vec_t vecs[11];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic apply_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      invalidate  = vecs[i].inv;
      instr_wait  = vecs[i].iw;
      next_thread = vecs[i].nt;
      #1;
      chk($sformatf("vec%0d_reload", i), int'(reload), int'(vecs[i].rel));
      cyc();
      chk($sformatf("vec%0d_stage", i), int'(stage_allow), int'(vecs[i].sa));
      chk($sformatf("vec%0d_almost", i), int'(almost), int'(vecs[i].alm));
    end
    invalidate = 1'b0; instr_wait = 1'b0; next_thread = 1'b0;
  endtask

  // which: 0 = thread_num_ahead, 1 = thread_num
  task automatic wait_for(input int which, input int val, input string nm);
    int cur;
    cur = (which == 0) ? int'(thread_num_ahead) : int'(thread_num);
    for (int k = 0; k < 64 && cur != val; k++) begin
      cyc();
      cur = (which == 0) ? int'(thread_num_ahead) : int'(thread_num);
    end
    chk(nm, cur, val);
  endtask

  task automatic init_sweep(input string nm);
    for (int i = 0; i < 16; i++) begin
      #1;
      chk({nm, "_init"}, int'(thread_init), 1);
      chk({nm, "_tnum"}, int'(thread_num), i);
      chk({nm, "_noreload"}, int'(reload), 0);
      cyc();
    end
    chk({nm, "_init_done"}, int'(thread_init), 0);
    chk({nm, "_tnum_wrap"}, int'(thread_num), 0);
  endtask

  // Scoreboard: every observed RELOAD must match a queued expected thread.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (prev_rel) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL sb_unexpected_reload: got thread %0d expected none", thread_num);
        end else begin
          chk("sb_thread", int'(thread_num), exp_q.pop_front());
        end
      end
      prev_rel = reload;
    end
  end

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0011, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0111, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0011, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0011, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0011, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0011, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0111, 1'b0};
    for (int i = 0; i < 16; i++) tstate[i] = THREAD_STATE_NONE;

    // Reset values
    repeat (3) cyc();
    chk("rst_tnum", int'(thread_num), 0);
    chk("rst_ahead", int'(thread_num_ahead), 0);
    chk("rst_rdnum", int'(ts_rd_num), 0);
    chk("rst_stage", int'(stage_allow), 0);
    chk("rst_almost", int'(almost), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_init", int'(thread_init), 1);
    rst = 1'b0;

    // Init sweep, then only thread 5 ready: pending switch from init loads it
    tstate[5] = THREAD_STATE_WR_RDY;
    exp_q.push_back(5);
    init_sweep("sweep1");
    chk("post_init_stage", int'(stage_allow), 0);
    chk("scan_start", int'(ts_rd_num), 0);
    repeat (5) cyc();
    chk("scan_at5", int'(ts_rd_num), 5);
    chk("scan_at5_noreload", int'(reload), 0);
    cyc();
    chk("sel5_ahead", int'(thread_num_ahead), 5);
    chk("sel5_hold_rdnum", int'(ts_rd_num), 5);
    apply_vecs(0, 3);
    chk("run5_tnum", int'(thread_num), 5);

    // Thread 9 pre-selected; invalidate then next_thread; then instr_wait stall
    tstate[5] = THREAD_STATE_RUNNING;
    tstate[9] = THREAD_STATE_WR_RDY;
    wait_for(0, 9, "sel9_ahead");
    exp_q.push_back(9);
    apply_vecs(4, 10);
    chk("run9_tnum", int'(thread_num), 9);
    chk("run9_err", int'(err), 0);

    // Pre-selected thread 3 drops out; switch waits for thread 7
    tstate[9] = THREAD_STATE_RUNNING;
    tstate[3] = THREAD_STATE_WR_RDY;
    wait_for(0, 3, "sel3_ahead");
    tstate[3] = THREAD_STATE_NONE;
    tstate[7] = THREAD_STATE_WR_RDY;
    cyc();
    chk("drop_rdnum", int'(ts_rd_num), 4);
    next_thread = 1'b1;
    exp_q.push_back(7);
    #1;
    chk("drop_nt_noreload", int'(reload), 0);
    cyc();
    next_thread = 1'b0;
    repeat (2) cyc();
    chk("drop_rdnum7", int'(ts_rd_num), 7);
    chk("drop_still_noreload", int'(reload), 0);
    cyc();
    chk("sel7_ahead", int'(thread_num_ahead), 7);
    chk("sel7_reload", int'(reload), 1);
    cyc();
    chk("run7_tnum", int'(thread_num), 7);
    chk("run7_stage", int'(stage_allow), 1);

    // Only the running thread is WR_RDY: never selected, switch waits
    repeat (20) cyc();
    next_thread = 1'b1;
    #1;
    chk("self_noreload", int'(reload), 0);
    cyc();
    next_thread = 1'b0;
    chk("self_tnum", int'(thread_num), 7);
    tstate[7]  = THREAD_STATE_RUNNING;
    tstate[12] = THREAD_STATE_WR_RDY;
    exp_q.push_back(12);
    wait_for(1, 12, "pend_run12");

    // Invalidate coinciding with reload sets sticky err
    tstate[12] = THREAD_STATE_RUNNING;
    tstate[14] = THREAD_STATE_WR_RDY;
    wait_for(0, 14, "sel14_ahead");
    invalidate = 1'b1; next_thread = 1'b1;
    exp_q.push_back(14);
    #1;
    chk("err_reload", int'(reload), 1);
    cyc();
    invalidate = 1'b0; next_thread = 1'b0;
    chk("err_set", int'(err), 1);
    chk("err_stage", int'(stage_allow), 1);
    chk("err_tnum", int'(thread_num), 14);
    repeat (3) cyc();
    chk("err_sticky", int'(err), 1);

    // Entry point switch with a switch pending: init restarts, no reload
    tstate[14] = THREAD_STATE_RUNNING;
    next_thread = 1'b1;
    #1;
    chk("eps_pend_noreload", int'(reload), 0);
    cyc();
    next_thread = 1'b0;
    entry_pt_switch = 1'b1;
    cyc();
    entry_pt_switch = 1'b0;
    tstate[2] = THREAD_STATE_WR_RDY;
    init_sweep("sweep2");
    exp_q.push_back(2);
    wait_for(1, 2, "post_eps_run2");
    repeat (2) cyc();
    chk("sb_drained", exp_q.size(), 0);
    chk("final_err", int'(err), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
